// File: rtl/llc_access_engine.sv
// Last-level cache access engine: MESI directory in flops, tree pseudo-LRU replacement,
// handshaked shared-bus and upper-level message ports, saturating statistics.
module llc_access_engine #(
  parameter int WAYS   = 8,
  parameter int SETS   = 64,
  parameter int LINE_B = 64,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_op,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              bus_valid,
  input  logic              bus_ready,
  output logic [2:0]        bus_op,
  output logic [ADDR_W-1:0] bus_addr,
  input  logic [1:0]        snoop_result,
  output logic              msg_valid,
  input  logic              msg_ready,
  output logic [2:0]        msg_type,
  output logic [ADDR_W-1:0] msg_addr,
  output logic              done,
  output logic              done_hit,
  output logic [31:0]       stat_reads,
  output logic [31:0]       stat_writes,
  output logic [31:0]       stat_hits,
  output logic [31:0]       stat_misses
);
  localparam int OFF_W = $clog2(LINE_B);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
  localparam int WAY_W = $clog2(WAYS);

  localparam logic [1:0] MESI_I = 2'd0, MESI_S = 2'd1, MESI_E = 2'd2, MESI_M = 2'd3;
  localparam logic [2:0] BUS_READ = 3'd1, BUS_WRITE = 3'd2, BUS_INVALIDATE = 3'd3, BUS_RWIM = 3'd4;
  localparam logic [2:0] MSG_GETLINE = 3'd1, MSG_SENDLINE = 3'd2, MSG_EVICTLINE = 3'd4;
  localparam logic [1:0] SNOOP_NOHIT = 2'd0;

  typedef enum logic [2:0] {
    ST_IDLE, ST_LOOKUP, ST_BUS_INV, ST_MSG_EVICT, ST_BUS_WB, ST_BUS_FILL, ST_MSG_SEND, ST_DONE
  } state_t;

  state_t              state_r;
  logic                op_r, hit_r, vic_dirty_r;
  logic [TAG_W-1:0]    req_tag_r;
  logic [IDX_W-1:0]    idx_r;
  logic [WAY_W-1:0]    way_r;
  logic [ADDR_W-1:0]   vic_line_r;
  logic [TAG_W-1:0]    tags_r [SETS][WAYS];
  logic [1:0]          mesi_r [SETS][WAYS];
  logic [WAYS-2:0]     plru_r [SETS];

  logic                hit_s, inv_found_s, commit_s;
  logic [WAY_W-1:0]    hit_way_s, inv_way_s, vic_way_s, commit_way_s;
  logic [1:0]          hit_mesi_s, commit_mesi_s;
  logic [WAY_W:0]      vic_node_s;
  logic [WAYS-1:0]     vic_tree_s;
  logic [ADDR_W-1:0]   req_line_s, vic_line_s;
  logic [2:0]          fill_op_s, send_type_s;
  logic                unused_offset_s;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Heap-ordered tree: node n has children 2n+1 (left) and 2n+2 (right); bits point away from w.
  function automatic logic [WAYS-2:0] plru_touch(input logic [WAYS-2:0] t, input logic [WAY_W-1:0] w);
    logic [WAYS-1:0]  tt;
    logic [WAY_W:0]   n;
    logic [WAY_W-1:0] ww;
    logic             b;
    tt = {1'b0, t};
    n  = '0;
    ww = w;
    for (int l = 0; l < WAY_W; l++) begin
      b  = ww[WAY_W-1];
      tt[n[WAY_W-1:0]] = ~b;
      n  = {n[WAY_W-1:0], 1'b0} + (WAY_W+1)'(1'b1) + (WAY_W+1)'(b);
      ww = ww << 1'b1;
    end
    return tt[WAYS-2:0];
  endfunction

  assign unused_offset_s = ^req_addr[OFF_W-1:0];
  assign req_line_s      = {req_tag_r, idx_r, {OFF_W{1'b0}}};
  assign fill_op_s       = op_r ? BUS_RWIM : BUS_READ;
  assign send_type_s     = op_r ? MSG_SENDLINE : MSG_GETLINE;

  // Directory lookup of the latched request: hit way, lowest invalid way, PLRU victim.
  always_comb begin
    hit_s       = 1'b0;
    hit_way_s   = '0;
    inv_found_s = 1'b0;
    inv_way_s   = '0;
    for (int w = WAYS-1; w >= 0; w--) begin
      hit_s       = hit_s | ((mesi_r[idx_r][w] != MESI_I) && (tags_r[idx_r][w] == req_tag_r));
      hit_way_s   = ((mesi_r[idx_r][w] != MESI_I) && (tags_r[idx_r][w] == req_tag_r)) ? WAY_W'(w) : hit_way_s;
      inv_found_s = inv_found_s | (mesi_r[idx_r][w] == MESI_I);
      inv_way_s   = (mesi_r[idx_r][w] == MESI_I) ? WAY_W'(w) : inv_way_s;
    end
    hit_mesi_s = mesi_r[idx_r][hit_way_s];
    vic_tree_s = {1'b0, plru_r[idx_r]};
    vic_node_s = '0;
    vic_way_s  = '0;
    for (int l = 0; l < WAY_W; l++) begin
      vic_way_s  = (vic_way_s << 1'b1) | WAY_W'(vic_tree_s[vic_node_s[WAY_W-1:0]]);
      vic_node_s = {vic_node_s[WAY_W-1:0], 1'b0} + (WAY_W+1)'(1'b1)
                 + (WAY_W+1)'(vic_tree_s[vic_node_s[WAY_W-1:0]]);
    end
    vic_line_s = {tags_r[idx_r][vic_way_s], idx_r, {OFF_W{1'b0}}};
  end

  // Directory commit happens only on the transition into MSG_SEND.
  always_comb begin
    commit_s      = 1'b0;
    commit_way_s  = way_r;
    commit_mesi_s = MESI_M;
    case (state_r)
      ST_LOOKUP: begin
        if (hit_s && !(op_r && (hit_mesi_s == MESI_S))) begin
          commit_s      = 1'b1;
          commit_way_s  = hit_way_s;
          commit_mesi_s = op_r ? MESI_M : hit_mesi_s;
        end else begin
          commit_s = 1'b0;
        end
      end
      ST_BUS_INV:  commit_s = bus_ready;
      ST_BUS_FILL: begin
        commit_s      = bus_ready;
        commit_mesi_s = op_r ? MESI_M : ((snoop_result == SNOOP_NOHIT) ? MESI_E : MESI_S);
      end
      default: commit_s = 1'b0;
    endcase
  end

  // Request FSM, output registers, statistics and directory state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      req_ready   <= 1'b0;
      bus_valid   <= 1'b0;
      bus_op      <= 3'd0;
      bus_addr    <= '0;
      msg_valid   <= 1'b0;
      msg_type    <= 3'd0;
      msg_addr    <= '0;
      done        <= 1'b0;
      done_hit    <= 1'b0;
      stat_reads  <= 32'd0;
      stat_writes <= 32'd0;
      stat_hits   <= 32'd0;
      stat_misses <= 32'd0;
      op_r        <= 1'b0;
      hit_r       <= 1'b0;
      vic_dirty_r <= 1'b0;
      req_tag_r   <= '0;
      idx_r       <= '0;
      way_r       <= '0;
      vic_line_r  <= '0;
      for (int s = 0; s < SETS; s++) begin
        plru_r[s] <= '0;
        for (int w = 0; w < WAYS; w++) begin
          tags_r[s][w] <= '0;
          mesi_r[s][w] <= MESI_I;
        end
      end
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            op_r      <= req_op;
            req_tag_r <= req_addr[ADDR_W-1 -: TAG_W];
            idx_r     <= req_addr[OFF_W +: IDX_W];
            req_ready <= 1'b0;
            state_r   <= ST_LOOKUP;
            if (req_op) stat_writes <= sat_inc(stat_writes);
            else        stat_reads  <= sat_inc(stat_reads);
          end else begin
            req_ready <= 1'b1;
          end
        end
        ST_LOOKUP: begin
          hit_r <= hit_s;
          if (hit_s) begin
            stat_hits <= sat_inc(stat_hits);
            way_r     <= hit_way_s;
            if (op_r && (hit_mesi_s == MESI_S)) begin
              bus_valid <= 1'b1;
              bus_op    <= BUS_INVALIDATE;
              bus_addr  <= req_line_s;
              state_r   <= ST_BUS_INV;
            end else begin
              msg_valid <= 1'b1;
              msg_type  <= send_type_s;
              msg_addr  <= req_line_s;
              state_r   <= ST_MSG_SEND;
            end
          end else begin
            stat_misses <= sat_inc(stat_misses);
            if (inv_found_s) begin
              way_r     <= inv_way_s;
              bus_valid <= 1'b1;
              bus_op    <= fill_op_s;
              bus_addr  <= req_line_s;
              state_r   <= ST_BUS_FILL;
            end else begin
              way_r       <= vic_way_s;
              vic_line_r  <= vic_line_s;
              vic_dirty_r <= (mesi_r[idx_r][vic_way_s] == MESI_M);
              msg_valid   <= 1'b1;
              msg_type    <= MSG_EVICTLINE;
              msg_addr    <= vic_line_s;
              state_r     <= ST_MSG_EVICT;
            end
          end
        end
        ST_BUS_INV, ST_BUS_FILL: begin
          if (bus_ready) begin
            bus_valid <= 1'b0;
            msg_valid <= 1'b1;
            msg_type  <= send_type_s;
            msg_addr  <= req_line_s;
            state_r   <= ST_MSG_SEND;
          end
        end
        ST_MSG_EVICT: begin
          if (msg_ready) begin
            msg_valid <= 1'b0;
            bus_valid <= 1'b1;
            if (vic_dirty_r) begin
              bus_op   <= BUS_WRITE;
              bus_addr <= vic_line_r;
              state_r  <= ST_BUS_WB;
            end else begin
              bus_op   <= fill_op_s;
              bus_addr <= req_line_s;
              state_r  <= ST_BUS_FILL;
            end
          end
        end
        ST_BUS_WB: begin
          if (bus_ready) begin
            bus_op   <= fill_op_s;
            bus_addr <= req_line_s;
            state_r  <= ST_BUS_FILL;
          end
        end
        ST_MSG_SEND: begin
          if (msg_ready) begin
            msg_valid <= 1'b0;
            done      <= 1'b1;
            done_hit  <= hit_r;
            state_r   <= ST_DONE;
          end
        end
        ST_DONE: begin
          done      <= 1'b0;
          done_hit  <= 1'b0;
          req_ready <= 1'b1;
          state_r   <= ST_IDLE;
        end
        default: state_r <= ST_IDLE;
      endcase
      if (commit_s) begin
        tags_r[idx_r][commit_way_s] <= req_tag_r;
        mesi_r[idx_r][commit_way_s] <= commit_mesi_s;
        plru_r[idx_r]               <= plru_touch(plru_r[idx_r], commit_way_s);
      end
    end
  end
endmodule

// File: tb/tb_llc_access_engine.sv
// Directed self-checking bench for llc_access_engine (8 ways, 64 sets, 64-byte lines).
module tb_llc_access_engine;
  logic        clk = 1'b0;
  logic        rst_n, req_valid, req_ready, req_op;
  logic [31:0] req_addr;
  logic        bus_valid, bus_ready;
  logic [2:0]  bus_op;
  logic [31:0] bus_addr;
  logic [1:0]  snoop_result;
  logic        msg_valid, msg_ready;
  logic [2:0]  msg_type;
  logic [31:0] msg_addr;
  logic        done, done_hit;
  logic [31:0] stat_reads, stat_writes, stat_hits, stat_misses;

  int          n_checks = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          t_acc, done_at, nb, nm;
  logic        hit_seen;
  logic [2:0]  rb_op [4];
  logic [31:0] rb_addr [4];
  logic [2:0]  rm_type [4];
  logic [31:0] rm_addr [4];

  llc_access_engine #(.WAYS(8), .SETS(64), .LINE_B(64), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_addr(req_addr),
    .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_op(bus_op), .bus_addr(bus_addr),
    .snoop_result(snoop_result),
    .msg_valid(msg_valid), .msg_ready(msg_ready), .msg_type(msg_type), .msg_addr(msg_addr),
    .done(done), .done_hit(done_hit),
    .stat_reads(stat_reads), .stat_writes(stat_writes), .stat_hits(stat_hits), .stat_misses(stat_misses)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_req(input logic op, input logic [31:0] addr, input logic [1:0] snoop);
    @(negedge clk);
    snoop_result = snoop;
    req_op    = op;
    req_addr  = addr;
    req_valid = 1'b1;
    nb = 0;
    nm = 0;
    for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
    chk("accept", req_ready, 1'b1);
    t_acc = cyc;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic collect();
    done_at  = -1;
    hit_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus_valid && bus_ready && nb < 4) begin
        rb_op[nb] = bus_op; rb_addr[nb] = bus_addr; nb++;
      end
      if (msg_valid && msg_ready && nm < 4) begin
        rm_type[nm] = msg_type; rm_addr[nm] = msg_addr; nm++;
      end
      if (done) begin
        done_at  = cyc - t_acc;
        hit_seen = done_hit;
        break;
      end
    end
  endtask

  task automatic txn(input logic op, input logic [31:0] addr, input logic [1:0] snoop);
    start_req(op, addr, snoop);
    collect();
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_op = 1'b0; req_addr = 32'd0;
    bus_ready = 1'b1; msg_ready = 1'b1; snoop_result = 2'd0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", req_ready, 1'b0);
    chk("rst_bus_valid", bus_valid, 1'b0);
    chk("rst_msg_valid", msg_valid, 1'b0);
    chk("rst_done", {done, done_hit}, 2'b00);
    chk("rst_ops", {bus_op, msg_type}, 6'd0);
    chk("rst_addrs", {bus_addr, msg_addr}, 64'd0);
    chk("rst_stats", {stat_reads | stat_writes | stat_hits | stat_misses}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", req_ready, 1'b1);

    // Write miss into an empty set: RWIM then SENDLINE.
    txn(1'b1, 32'h0000_1044, 2'd0);
    chk("t1_nbus", nb, 1);
    chk("t1_bus", {rb_op[0], rb_addr[0]}, {3'd4, 32'h0000_1040});
    chk("t1_msg", {rm_type[0], rm_addr[0]}, {3'd2, 32'h0000_1040});
    chk("t1_done_at", done_at, 4);
    chk("t1_done_hit", hit_seen, 1'b0);
    @(negedge clk);
    chk("t1_ready_after_done", req_ready, 1'b1);
    chk("t1_stat_writes", stat_writes, 32'd1);
    chk("t1_stat_misses", stat_misses, 32'd1);

    // Read miss with snoop HIT lands in S; a write then needs INVALIDATE.
    txn(1'b0, 32'h2000_0080, 2'd1);
    chk("t2r_bus", {rb_op[0], rb_addr[0]}, {3'd1, 32'h2000_0080});
    chk("t2r_msg", {rm_type[0], rm_addr[0]}, {3'd1, 32'h2000_0080});
    chk("t2r_done_at", done_at, 4);
    txn(1'b1, 32'h2000_0080, 2'd0);
    chk("t2w_nbus", nb, 1);
    chk("t2w_bus", {rb_op[0], rb_addr[0]}, {3'd3, 32'h2000_0080});
    chk("t2w_msg", {rm_type[0], rm_addr[0]}, {3'd2, 32'h2000_0080});
    chk("t2w_done_at", done_at, 4);
    chk("t2w_done_hit", hit_seen, 1'b1);
    chk("t2_stat_hits", stat_hits, 32'd1);
    chk("t2_stat_rw", {stat_reads, stat_writes}, {32'd1, 32'd2});

    // Both lines are now M: write hits complete in 3 cycles with no bus traffic.
    txn(1'b1, 32'h0000_1044, 2'd0);
    chk("t1m_nbus", nb, 0);
    chk("t1m_done", {done_at[3:0], hit_seen}, {4'd3, 1'b1});
    txn(1'b1, 32'h2000_0080, 2'd0);
    chk("t2m_nbus", nb, 0);
    chk("t2m_done", {done_at[3:0], hit_seen}, {4'd3, 1'b1});

    // Fill all eight ways of set 0 with dirty lines, then force a dirty eviction of way 0.
    for (int t = 1; t <= 8; t++) begin
      txn(1'b1, 32'h1000 * t, 2'd0);
      chk("t3_fill_done_at", done_at, 4);
    end
    txn(1'b1, 32'h0000_9000, 2'd0);
    chk("t3_nbus", nb, 2);
    chk("t3_nmsg", nm, 2);
    chk("t3_evict", {rm_type[0], rm_addr[0]}, {3'd4, 32'h0000_1000});
    chk("t3_wb", {rb_op[0], rb_addr[0]}, {3'd2, 32'h0000_1000});
    chk("t3_rwim", {rb_op[1], rb_addr[1]}, {3'd4, 32'h0000_9000});
    chk("t3_send", {rm_type[1], rm_addr[1]}, {3'd2, 32'h0000_9000});
    chk("t3_done_at", done_at, 6);
    chk("t3_done_hit", hit_seen, 1'b0);
    txn(1'b0, 32'h0000_9000, 2'd0);
    chk("t3_tag9_hit", {done_at[3:0], hit_seen}, {4'd3, 1'b1});
    chk("t3_stats_rw", {stat_reads, stat_writes}, {32'd2, 32'd13});
    chk("t3_stats_hm", {stat_hits, stat_misses}, {32'd4, 32'd11});

    // Reset, then clean E lines in set 1 and a clean eviction.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t4_rst_stats", {stat_reads | stat_writes | stat_hits | stat_misses}, 32'd0);
    rst_n = 1'b1;
    for (int t = 1; t <= 8; t++) begin
      txn(1'b0, (32'h1000 * t) | 32'h40, 2'd0);
      chk("t4_fill_done_at", done_at, 4);
    end
    txn(1'b0, 32'h0000_9040, 2'd0);
    chk("t4_nbus", nb, 1);
    chk("t4_evict", {rm_type[0], rm_addr[0]}, {3'd4, 32'h0000_1040});
    chk("t4_read", {rb_op[0], rb_addr[0]}, {3'd1, 32'h0000_9040});
    chk("t4_getline", {rm_type[1], rm_addr[1]}, {3'd1, 32'h0000_9040});
    chk("t4_done_at", done_at, 5);
    chk("t4_stats", {stat_reads, stat_misses}, {32'd9, 32'd9});

    // Bus backpressure during the fill.
    bus_ready = 1'b0;
    start_req(1'b0, 32'h0000_A0C0, 2'd0);
    @(negedge clk);
    chk("t5_lookup_bus_valid", bus_valid, 1'b0);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("t5_hold_valid", bus_valid, 1'b1);
      chk("t5_hold_op", bus_op, 3'd1);
      chk("t5_hold_addr", bus_addr, 32'h0000_A0C0);
      chk("t5_hold_ready", req_ready, 1'b0);
      chk("t5_hold_done", done, 1'b0);
      @(negedge clk);
    end
    bus_ready = 1'b1;
    collect();
    chk("t5_done_at", done_at, 9);
    chk("t5_msg", {rm_type[0], rm_addr[0]}, {3'd1, 32'h0000_A0C0});

    // Reset while the fill is stalled; the line must not survive.
    bus_ready = 1'b0;
    start_req(1'b0, 32'h0000_B100, 2'd0);
    @(negedge clk);
    @(negedge clk);
    chk("t6_in_fill", bus_valid, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t6_rst_valids", {bus_valid, msg_valid, done, req_ready}, 4'b0000);
    rst_n = 1'b1;
    bus_ready = 1'b1;
    @(negedge clk);
    chk("t6_ready", req_ready, 1'b1);
    txn(1'b0, 32'h0000_B100, 2'd0);
    chk("t6_done", {done_at[3:0], hit_seen}, {4'd4, 1'b0});
    chk("t6_stats", {stat_reads, stat_misses}, {32'd1, 32'd1});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule

// File: doc/llc_access_engine.md
# llc_access_engine

Parametrised, synthesizable last-level-cache access controller that services both processor reads and processor writes against an N-way set-associative directory with MESI state and tree pseudo-LRU replacement. It sits between the processor request port and two handshaked outputs: the shared bus (READ / WRITE / INVALIDATE / RWIM with snoop result) and the upper-level cache message port (GETLINE / SENDLINE / INVALIDATELINE / EVICTLINE). Compared with the earlier write-only behavioural model, it adds read service, dirty-victim write-back, backpressure on every output, and configurable geometry.

## Interface
- WAYS, 8: associativity; power of 2, ≥2
- SETS, 64: number of sets; power of 2
- LINE_B, 64: line size in bytes; power of 2
- ADDR_W, 32: address width; TAG_W = ADDR_W − log2(SETS) − log2(LINE_B)
- clk  in  1  clock; all logic is rising-edge
- rst_n  in  1  synchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  engine idle and able to accept
- req_op  in  1  0 = read, 1 = write
- req_addr  in  ADDR_W  byte address
- bus_valid  out  1  bus operation pending
- bus_ready  in  1  bus accepts the operation; snoop_result is valid this cycle
- bus_op  out  3  1 = READ, 2 = WRITE, 3 = INVALIDATE, 4 = RWIM
- bus_addr  out  ADDR_W  line-aligned address (offset bits zero)
- snoop_result  in  2  0 = NOHIT, 1 = HIT, 2 = HITM
- msg_valid / msg_ready  out / in  1  upper-level message handshake
- msg_type  out  3  1 = GETLINE, 2 = SENDLINE, 3 = INVALIDATELINE, 4 = EVICTLINE
- msg_addr  out  ADDR_W  line-aligned address
- done  out  1  one-cycle pulse at request completion
- done_hit  out  1  valid with done; 1 = hit
- stat_reads, stat_writes, stat_hits, stat_misses  out  32  saturating counters

## Operation
- Address split: offset [log2(LINE_B)−1:0], index next log2(SETS) bits, tag the remaining bits.
- Directory is held in flops: per set, per way, a TAG_W tag and a 2-bit MESI field (I = 0, S = 1, E = 2, M = 3), plus WAYS−1 PLRU tree bits.
- PLRU tree: bit 0 = the victim walk goes left, 1 = goes right. On an access, every bit on the accessed way's path is set to point away from that way.
- States: IDLE → LOOKUP → {BUS_INV, MSG_EVICT, BUS_WB, BUS_FILL, MSG_SEND} → DONE → IDLE.
- IDLE: req_ready = 1. On handshake, latch op and address, increment stat_reads or stat_writes, then go to LOOKUP.
- LOOKUP (1 cycle): a hit is a way with MESI ≠ I and a matching tag. Increment stat_hits or stat_misses.
  - Read hit → MSG_SEND.
  - Write hit in S → BUS_INV (INVALIDATE). Write hit in E or M → MSG_SEND.
  - Miss with at least one way in I → lowest-index invalid way → BUS_FILL.
  - Miss with the set full → PLRU victim → MSG_EVICT.
- MSG_EVICT: send EVICTLINE with the victim address ({victim tag, index, 0}). Then go to BUS_WB if the victim is M, else BUS_FILL.
- BUS_WB: bus WRITE of the victim address, then BUS_FILL.
- BUS_FILL: read issues READ, write issues RWIM. Resulting state:
  - read with NOHIT → E
  - read with HIT or HITM → S
  - write → M
- MSG_SEND: read sends GETLINE, write sends SENDLINE; address is the request line.
- Commit point: on entry to MSG_SEND, write the tag and MESI (hit write → M) and update PLRU. Nothing is committed earlier.
- DONE: pulse done, then return to IDLE.
- Counters saturate at 0xFFFF_FFFF.

## Timing
- Reset values: req_ready = 0 during reset, 1 on the first cycle after rst_n rises. bus_valid, msg_valid, done and done_hit = 0. bus_op, msg_type, addresses = 0. All MESI = I, PLRU = 0, counters = 0.
- Reset asserted mid-request: on the next edge the FSM goes to IDLE and all valids drop. The directory is cleared; no partial commit survives.
- Output handshakes: *_valid and its op/type/addr stay stable until the matching ready is sampled high; the transfer completes that cycle. snoop_result is sampled only on the bus transfer cycle.
- Minimum latencies, ready signals tied high, request accepted at cycle T:
  - hit in E or M: done at T+3
  - hit in S (write): done at T+4
  - miss into an invalid way: done at T+4
  - full-set miss with clean victim: done at T+5
  - full-set miss with dirty victim: done at T+6
- req_ready is 0 from T+1 until the cycle after done; a new request can be accepted the cycle after done.

## Test plan
WAYS = 8, SETS = 64, LINE_B = 64, ADDR_W = 32 (index = addr[11:6]).
- Write 0x0000_1044 into an empty cache → bus RWIM 0x0000_1040, then SENDLINE 0x0000_1040. Way 0 becomes M. done with done_hit = 0. stat_writes = 1, stat_misses = 1.
- Read 0x2000_0080 with snoop HIT → bus READ, GETLINE; line ends in S. Then write the same address → INVALIDATE 0x2000_0080, SENDLINE, state M, done_hit = 1, stat_hits = 1.
- Writes to 0x1000, 0x2000, … 0x8000 (fills ways 0–7), then write 0x9000 → EVICTLINE 0x1000, bus WRITE 0x1000, RWIM 0x9000, SENDLINE 0x9000. Way 0 holds tag 0x9. done at T+6.
- Reads with snoop NOHIT fill ways 0–7 of index 1 in E, then read a ninth tag → EVICTLINE of way 0's line, no bus WRITE, then READ. done at T+5.
- Hold bus_ready low for 5 cycles during BUS_FILL → bus_valid, bus_op and bus_addr stay stable, req_ready = 0, no done until bus_ready rises.
- Assert rst_n = 0 for 1 cycle during BUS_FILL → all valids are 0 the next cycle. A repeat read of the same address then misses (stat_misses = 1 after reset).
